// File: rtl/fpu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// fpu_cmd_sequencer
//
// Instruction sequencer placed in front of the FPU. Incoming 32-bit words are
// buffered in a DEPTH-entry FIFO and issued one at a time on fpu_instr.
// Register loads issue one per cycle; FP arithmetic ops are held on fpu_instr
// until the FPU signals complete, and their result is captured, together with
// an error code, into a one-entry result buffer with a valid/ready handshake.
//
// Optional build macro:
//   FPU_SEQ_WATCHDOG_EN - when defined, an FP op that waits TIMEOUT cycles
//                         without complete is abandoned with res_err = 2'b10.
//                         When undefined the sequencer waits indefinitely.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   in_valid/in_instr instruction offer; in_ready = FIFO has room
//   fpu_instr         word driven to the FPU instruction input
//   fpu_complete      FPU done; fpu_wrong = FPU exception flag
//   fpu_out_32/64     FPU single/double results
//   res_valid/ready   result buffer handshake
//   res_data          captured result (single results zero-extended)
//   res_is64          result taken from fpu_out_64
//   res_err           00 ok, 01 fpu_wrong, 10 timeout, 11 illegal opcode
//   busy              FSM not idle or FIFO not empty
//   level             FIFO occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module fpu_cmd_sequencer #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 64,
    parameter int LW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [31:0]   in_instr,
    output logic          in_ready,
    output logic [31:0]   fpu_instr,
    input  logic          fpu_complete,
    input  logic          fpu_wrong,
    input  logic [31:0]   fpu_out_32,
    input  logic [63:0]   fpu_out_64,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [63:0]   res_data,
    output logic          res_is64,
    output logic [1:0]    res_err,
    output logic          busy,
    output logic [LW-1:0] level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [5:0] OP_LOAD = 6'b001111;
    localparam logic [5:0] OP_FPOP = 6'b010001;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_WRONG   = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    // FIFO storage (data only, never reset)
    logic [31:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          init_q;

    state_t        state_q, state_d;
    logic [31:0]   fpu_instr_q, fpu_instr_d;
    logic [63:0]   res_data_q, res_data_d;
    logic          res_is64_q, res_is64_d;
    logic [1:0]    res_err_q, res_err_d;
    logic          first_q, first_d;   // first WAIT cycle: ignore a stale complete
    logic          fmt32_q, fmt32_d;   // fmt[4] of the op in flight

`ifdef FPU_SEQ_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    logic [WW-1:0] wdog_q, wdog_d;
`else
    localparam int UNUSED_TIMEOUT = TIMEOUT;
`endif

    logic        push;
    logic        pop;
    logic [31:0] head;

    // in_ready is held low until the first clock after reset release
    assign in_ready  = init_q && (level_q != LW'(DEPTH));
    assign fpu_instr = fpu_instr_q;
    assign res_valid = (state_q == S_RESULT);
    assign res_data  = res_data_q;
    assign res_is64  = res_is64_q;
    assign res_err   = res_err_q;
    assign busy      = (state_q != S_IDLE) || (level_q != '0);
    assign level     = level_q;

    always_comb begin
        push        = in_valid && in_ready;
        pop         = 1'b0;
        head        = mem[rd_ptr_q];
        state_d     = state_q;
        fpu_instr_d = fpu_instr_q;
        res_data_d  = res_data_q;
        res_is64_d  = res_is64_q;
        res_err_d   = res_err_q;
        first_d     = first_q;
        fmt32_d     = fmt32_q;
`ifdef FPU_SEQ_WATCHDOG_EN
        wdog_d      = wdog_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    pop = 1'b1;
                    if (head[31:26] == OP_LOAD) begin
                        fpu_instr_d = head;
                    end else if (head == 32'h0) begin
                        fpu_instr_d = 32'h0;
                    end else if (head[31:26] == OP_FPOP) begin
                        fpu_instr_d = head;
                        fmt32_d     = head[25];
                        first_d     = 1'b1;
`ifdef FPU_SEQ_WATCHDOG_EN
                        wdog_d      = '0;
`endif
                        state_d     = S_WAIT;
                    end else begin
                        fpu_instr_d = 32'h0;
                        res_data_d  = 64'h0;
                        res_is64_d  = 1'b0;
                        res_err_d   = ERR_ILLEGAL;
                        state_d     = S_RESULT;
                    end
                end else begin
                    fpu_instr_d = 32'h0;
                end
            end

            S_WAIT: begin
                first_d = 1'b0;
`ifdef FPU_SEQ_WATCHDOG_EN
                wdog_d  = wdog_q + WW'(1);
`endif
                if (!first_q && fpu_complete) begin
                    res_data_d  = fmt32_q ? {32'h0, fpu_out_32} : fpu_out_64;
                    res_is64_d  = !fmt32_q;
                    res_err_d   = fpu_wrong ? ERR_WRONG : ERR_OK;
                    fpu_instr_d = 32'h0;
                    state_d     = S_RESULT;
                end
`ifdef FPU_SEQ_WATCHDOG_EN
                else if (wdog_q == WW'(TIMEOUT - 1)) begin
                    res_data_d  = 64'h0;
                    res_is64_d  = 1'b0;
                    res_err_d   = ERR_TIMEOUT;
                    fpu_instr_d = 32'h0;
                    state_d     = S_RESULT;
                end
`endif
            end

            S_RESULT: begin
                // no pop in the handshake cycle; IDLE pops on the next cycle
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_instr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            init_q      <= 1'b0;
            state_q     <= S_IDLE;
            fpu_instr_q <= 32'h0;
            res_data_q  <= 64'h0;
            res_is64_q  <= 1'b0;
            res_err_q   <= 2'b00;
            first_q     <= 1'b0;
            fmt32_q     <= 1'b0;
`ifdef FPU_SEQ_WATCHDOG_EN
            wdog_q      <= '0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            init_q      <= 1'b1;
            state_q     <= state_d;
            fpu_instr_q <= fpu_instr_d;
            res_data_q  <= res_data_d;
            res_is64_q  <= res_is64_d;
            res_err_q   <= res_err_d;
            first_q     <= first_d;
            fmt32_q     <= fmt32_d;
`ifdef FPU_SEQ_WATCHDOG_EN
            wdog_q      <= wdog_d;
`endif
        end
    end

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
module tb_fpu_cmd_sequencer;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 64;
    localparam int LW      = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [31:0]   in_instr = 32'h0;
    logic          in_ready;
    logic [31:0]   fpu_instr;
    logic          fpu_complete = 1'b0;
    logic          fpu_wrong = 1'b0;
    logic [31:0]   fpu_out_32 = 32'h0;
    logic [63:0]   fpu_out_64 = 64'h0;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [63:0]   res_data;
    logic          res_is64;
    logic [1:0]    res_err;
    logic          busy;
    logic [LW-1:0] level;

    fpu_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .fpu_instr(fpu_instr),
        .fpu_complete(fpu_complete), .fpu_wrong(fpu_wrong),
        .fpu_out_32(fpu_out_32), .fpu_out_64(fpu_out_64),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_is64(res_is64), .res_err(res_err),
        .busy(busy), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        is64;
        logic [1:0]  err;
    } res_t;

    res_t        sb_q[$];
    logic [31:0] iss_q[$];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_res(input logic [63:0] d, input logic i64, input logic [1:0] e);
        res_t r;
        r.data = d; r.is64 = i64; r.err = e;
        sb_q.push_back(r);
    endtask

    // Result monitor: compares every accepted result against the scoreboard.
    always @(negedge clk) begin
        #2;
        if (rst && res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                total++; bad++;
                $display("FAIL res_unexpected: got data=%h err=%b expected none", res_data, res_err);
            end else begin
                res_t e;
                e = sb_q.pop_front();
                chk("res_data", res_data, e.data);
                chk("res_err", {62'h0, res_err}, {62'h0, e.err});
                if (e.err != 2'b10) chk("res_is64", {63'h0, res_is64}, {63'h0, e.is64});
            end
        end
    end

    // Issue monitor: every new non-zero word on fpu_instr must be the next expected issue.
    logic [31:0] prev_instr = 32'h0;
    always @(negedge clk) begin
        #2;
        if (fpu_instr !== prev_instr && fpu_instr != 32'h0) begin
            if (iss_q.size() == 0) begin
                total++; bad++;
                $display("FAIL issue_unexpected: got %h expected none", fpu_instr);
            end else begin
                chk("issue_order", {32'h0, fpu_instr}, {32'h0, iss_q.pop_front()});
            end
        end
        prev_instr = fpu_instr;
    end

    task automatic push(input logic [31:0] w, input bit issues, output bit acc);
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = w;
        acc = in_ready;
        if (acc && issues) iss_q.push_back(w);
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 1'b0;
        in_instr = 32'h0;
    endtask

    task automatic wait_instr(input logic [31:0] w);
        for (int i = 0; i < 40; i++) begin
            if (fpu_instr === w) break;
            @(negedge clk);
        end
        chk("fpop_issue", {32'h0, fpu_instr}, {32'h0, w});
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    bit acc;
    bit acc_log[DEPTH+2];

    initial begin
        // ---------------- reset state ----------------
        run_cycles(2);
        chk("rst_fpu_instr", {32'h0, fpu_instr}, 64'h0);
        chk("rst_res_valid", {63'h0, res_valid}, 64'h0);
        chk("rst_res_data", res_data, 64'h0);
        chk("rst_in_ready", {63'h0, in_ready}, 64'h0);
        chk("rst_level", {{(64-LW){1'b0}}, level}, 64'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", {63'h0, in_ready}, 64'h1);

        // ---------------- three back-to-back LOADs ----------------
        push(32'h3C01C000, 1, acc);
        push(32'h3C026511, 1, acc);
        push(32'h3C034200, 1, acc);
        idle_in();
        chk("load_w1", {32'h0, fpu_instr}, 64'h3C026511);
        @(negedge clk);
        chk("load_w2", {32'h0, fpu_instr}, 64'h3C034200);
        @(negedge clk);
        chk("load_zero", {32'h0, fpu_instr}, 64'h0);
        chk("load_no_res", {63'h0, res_valid}, 64'h0);

        // ---------------- FPOP single, complete after 10 cycles ----------------
        expect_res(64'h0000_0000_4049_0FDB, 1'b0, 2'b00);
        push(32'h46011242, 1, acc);
        idle_in();
        wait_instr(32'h46011242);
        for (int k = 1; k <= 10; k++) begin
            chk("fpop_held", {32'h0, fpu_instr}, 64'h46011242);
            if (k == 10) begin
                fpu_complete = 1'b1;
                fpu_out_32   = 32'h40490FDB;
            end
            @(negedge clk);
        end
        fpu_complete = 1'b0;
        chk("fpop_res_valid", {63'h0, res_valid}, 64'h1);
        chk("fpop_instr_cleared", {32'h0, fpu_instr}, 64'h0);
        @(negedge clk);

        // ---------------- stale complete on the first WAIT cycle is ignored ----------------
        expect_res(64'h0000_0000_3F80_0000, 1'b0, 2'b00);
        fpu_out_32 = 32'h3F800000;
        push(32'h46011246, 1, acc);
        idle_in();
        fpu_complete = 1'b1;
        wait_instr(32'h46011246);
        @(negedge clk);
        chk("stale_guard_held", {32'h0, fpu_instr}, 64'h46011246);
        chk("stale_guard_no_res", {63'h0, res_valid}, 64'h0);
        @(negedge clk);
        fpu_complete = 1'b0;
        chk("stale_guard_res", {63'h0, res_valid}, 64'h1);
        @(negedge clk);

        // ---------------- FPOP double with wrong flag, consumer stalled ----------------
        expect_res(64'h4009_21FB_5444_2D18, 1'b1, 2'b01);
        res_ready = 1'b0;
        push(32'h44200042, 1, acc);
        idle_in();
        wait_instr(32'h44200042);
        @(negedge clk);
        fpu_complete = 1'b1;
        fpu_wrong    = 1'b1;
        fpu_out_64   = 64'h400921FB54442D18;
        @(negedge clk);
        fpu_complete = 1'b0;
        fpu_wrong    = 1'b0;
        fpu_out_64   = 64'hDEADBEEF_CAFEF00D;
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", {63'h0, res_valid}, 64'h1);
            chk("hold_data", res_data, 64'h400921FB54442D18);
            chk("hold_is64", {63'h0, res_is64}, 64'h1);
            chk("hold_err", {62'h0, res_err}, 64'h1);
            chk("hold_busy", {63'h0, busy}, 64'h1);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("after_hs_valid", {63'h0, res_valid}, 64'h0);
        chk("after_hs_busy", {63'h0, busy}, 64'h0);

        // ---------------- FIFO overflow with the FPU stalled ----------------
        expect_res(64'h0000_0000_3F80_0001, 1'b0, 2'b00);
        push(32'h46011243, 1, acc);
        idle_in();
        wait_instr(32'h46011243);
        for (int i = 0; i < DEPTH + 2; i++) begin
            push(32'h3C100000 + i, 1, acc);
            acc_log[i] = acc;
        end
        idle_in();
        chk("ovf_acc_15", {63'h0, acc_log[DEPTH-1]}, 64'h1);
        chk("ovf_rej_16", {63'h0, acc_log[DEPTH]}, 64'h0);
        chk("ovf_rej_17", {63'h0, acc_log[DEPTH+1]}, 64'h0);
        chk("ovf_level", {{(64-LW){1'b0}}, level}, 64'(DEPTH));
        chk("ovf_in_ready", {63'h0, in_ready}, 64'h0);
        chk("ovf_fpop_held", {32'h0, fpu_instr}, 64'h46011243);
        fpu_complete = 1'b1;
        fpu_out_32   = 32'h3F800001;
        @(negedge clk);
        fpu_complete = 1'b0;
        run_cycles(DEPTH + 4);
        chk("ovf_drained", {{(64-LW){1'b0}}, level}, 64'h0);
        chk("ovf_all_issued", 64'(iss_q.size()), 64'h0);

        // ---------------- ILLEGAL word then NOP ----------------
        expect_res(64'h0, 1'b0, 2'b11);
        push(32'hFFFFFFFF, 0, acc);
        push(32'h00000000, 0, acc);
        idle_in();
        run_cycles(5);
        chk("illegal_nop_instr", {32'h0, fpu_instr}, 64'h0);

`ifdef FPU_SEQ_WATCHDOG_EN
        // ---------------- watchdog expiry ----------------
        expect_res(64'h0, 1'b0, 2'b10);
        push(32'h46011244, 1, acc);
        idle_in();
        wait_instr(32'h46011244);
        for (int k = 1; k <= TIMEOUT; k++) begin
            if (k == TIMEOUT) chk("wdog_held_last", {32'h0, fpu_instr}, 64'h46011244);
            @(negedge clk);
        end
        chk("wdog_res_valid", {63'h0, res_valid}, 64'h1);
        chk("wdog_instr_cleared", {32'h0, fpu_instr}, 64'h0);
        @(negedge clk);
`endif

        // ---------------- reset during WAIT ----------------
        push(32'h46011245, 1, acc);
        push(32'h3C200000, 0, acc);
        idle_in();
        wait_instr(32'h46011245);
        run_cycles(3);
        #3 rst = 1'b0;
        #1;
        chk("rstw_instr", {32'h0, fpu_instr}, 64'h0);
        chk("rstw_level", {{(64-LW){1'b0}}, level}, 64'h0);
        chk("rstw_res_valid", {63'h0, res_valid}, 64'h0);
        fpu_complete = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        fpu_complete = 1'b0;
        chk("rstw_in_ready", {63'h0, in_ready}, 64'h1);
        chk("rstw_busy", {63'h0, busy}, 64'h0);
        run_cycles(4);
        chk("rstw_no_res", {63'h0, res_valid}, 64'h0);

        // ---------------- end of run ----------------
        run_cycles(3);
        chk("sb_empty", 64'(sb_q.size()), 64'h0);
        chk("iss_empty", 64'(iss_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
